mcpu_multicycle: RTL and testbench

- Multi-cycle RV32I core; next generation of the single-cycle MCPU top.
- Shares decode, immediate, ALU and branch semantics with the single-cycle core, but time-multiplexes one unified memory port through a state machine.
- Memory is accessed through a ready/request handshake with arbitrary wait states, replacing the single-cycle core's zero-latency ROM/RAM.
- Adds halt/trap detection, a retire pulse and an instret counter for bench and debug observation.

---
 rtl/mcpu_multicycle.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mcpu_multicycle.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_multicycle.sv
// Multi-cycle RV32I core with one shared memory port.
// A state machine steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// over a req/ready handshake that tolerates any number of wait states.
module mcpu_multicycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted,
  output logic                 trap,
  output logic [31:0]          pc_dbg
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  state_t      state;
  logic [31:0] pc, ir, a, b, imm, r, mdr;
  logic [31:0] rf [0:31];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_system;

  assign opcode    = ir[6:0];
  assign rd        = ir[11:7];
  assign funct3    = ir[14:12];
  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];
  assign funct7    = ir[31:25];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_system = (opcode == OP_SYSTEM);
  assign pc_dbg    = pc;

  // A store retires on the handshake edge; every other instruction retires
  // in EXEC (branches) or WB, so the pulse lines up with the PC update edge.
  assign retire = (state == S_WB) || (state == S_EXEC && is_branch) ||
                  (state == S_MEM && is_store && mem_req && mem_ready);

  logic [31:0] imm_gen, rs1_val, rs2_val, op_b, alu_out, exec_result;
  logic [31:0] ls_addr, br_next, wb_next, wb_value, st_data, ld_value, ld_shift;
  logic [3:0]  st_strb;
  logic        legal, br_taken, misaligned, rf_we;

  // Decode, immediate generation, ALU, branch compare and load/store lane logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // statements leaves a value unassigned, which would infer a latch.
    imm_gen  = '0;
    legal    = 1'b0;
    alu_out  = '0;
    br_taken = 1'b0;
    st_data  = b;
    st_strb  = 4'b1111;
    ld_value = '0;
    rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

    unique case (opcode)
      OP_LUI, OP_AUIPC: imm_gen = {ir[31:12], 12'b0};
      OP_JAL:    imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OP_BRANCH: imm_gen = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_STORE:  imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      default:   imm_gen = {{20{ir[31]}}, ir[31:20]};
    endcase

    unique case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE: legal = 1'b1;
      OP_JALR:   legal = (funct3 == 3'b000);
      OP_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      OP_LOAD:   legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OP_STORE:  legal = (funct3 <= 3'b010);
      OP_IMM:    legal = (funct3 == 3'b001) ? (funct7 == 7'h00) :
                         (funct3 == 3'b101) ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;
      OP_REG:    legal = (funct7 == 7'h00) ||
                         (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
      OP_SYSTEM: legal = (ir == 32'h0000_0073) || (ir == 32'h0010_0073);
      default:   legal = 1'b0;
    endcase

    op_b = (opcode == OP_REG) ? b : imm;
    unique case (funct3)
      3'b000: alu_out = (opcode == OP_REG && funct7[5]) ? a - op_b : a + op_b;
      3'b001: alu_out = a << op_b[4:0];
      3'b010: alu_out = {31'b0, $signed(a) < $signed(op_b)};
      3'b011: alu_out = {31'b0, a < op_b};
      3'b100: alu_out = a ^ op_b;
      3'b101: alu_out = funct7[5] ? 32'($signed(a) >>> op_b[4:0]) : a >> op_b[4:0];
      3'b110: alu_out = a | op_b;
      default: alu_out = a & op_b;
    endcase

    unique case (funct3)
      3'b000:  br_taken = (a == b);
      3'b001:  br_taken = (a != b);
      3'b100:  br_taken = $signed(a) < $signed(b);
      3'b101:  br_taken = $signed(a) >= $signed(b);
      3'b110:  br_taken = a < b;
      default: br_taken = a >= b;
    endcase

    ls_addr    = a + imm;
    misaligned = (funct3[1:0] == 2'b01 && ls_addr[0]) ||
                 (funct3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00);
    unique case (opcode)
      OP_LUI:            exec_result = imm;
      OP_AUIPC:          exec_result = pc + imm;
      OP_LOAD, OP_STORE: exec_result = ls_addr;
      default:           exec_result = alu_out;
    endcase

    unique case (funct3[1:0])
      2'b00: begin st_data = {4{b[7:0]}};  st_strb = 4'b0001 << ls_addr[1:0]; end
      2'b01: begin st_data = {2{b[15:0]}}; st_strb = 4'b0011 << ls_addr[1:0]; end
      default: begin st_data = b;          st_strb = 4'b1111; end
    endcase

    ld_shift = mem_rdata >> {r[1:0], 3'b000};
    unique case (funct3)
      3'b000:  ld_value = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_value = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_value = {24'b0, ld_shift[7:0]};
      3'b101:  ld_value = {16'b0, ld_shift[15:0]};
      default: ld_value = mem_rdata;
    endcase

    br_next  = br_taken ? pc + imm : pc + 32'd4;
    wb_next  = is_jal ? pc + imm : is_jalr ? ((a + imm) & ~32'd1) : pc + 32'd4;
    wb_value = is_load ? mdr : (is_jal || is_jalr) ? pc + 32'd4 : r;
    rf_we    = !rst && (state == S_WB) && (rd != 5'd0) && (opcode != OP_FENCE);
  end

  // NOTE: the register file has no reset; x0 is never written and reads as
  // zero through the read mux, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (rf_we) rf[rd] <= wb_value;
  end

  // Instruction sequencer; owns PC, datapath latches and all memory-port outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      imm       <= '0;
      r         <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= RESET_PC;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      instret   <= '0;
      halted    <= 1'b0;
      trap      <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (!mem_req) begin
            // First fetch after reset: issue the request from the PC.
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= pc;
          end else if (mem_ready) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a   <= rs1_val;
          b   <= rs2_val;
          imm <= imm_gen;
          if (legal) begin
            state <= S_EXEC;
          end else begin
            state  <= S_TRAP;
            halted <= 1'b1;
            trap   <= 1'b1;
          end
        end
        S_EXEC: begin
          r <= exec_result;
          if (is_branch) begin
            pc       <= br_next;
            instret  <= instret + INSTRET_W'(1);
            state    <= S_FETCH;
            mem_req  <= 1'b1;
            mem_addr <= br_next;
          end else if (is_load || is_store) begin
            if (misaligned) begin
              state  <= S_TRAP;
              halted <= 1'b1;
              trap   <= 1'b1;
            end else begin
              state     <= S_MEM;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {ls_addr[31:2], 2'b00};
              mem_wdata <= st_data;
              mem_wstrb <= is_store ? st_strb : 4'b0000;
            end
          end else if (is_system) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            if (is_store) begin
              // Chain straight into the next fetch; mem_req stays high.
              pc       <= pc + 32'd4;
              instret  <= instret + INSTRET_W'(1);
              mem_addr <= pc + 32'd4;
              state    <= S_FETCH;
            end else begin
              mdr     <= ld_value;
              mem_req <= 1'b0;
              state   <= S_WB;
            end
          end
        end
        S_WB: begin
          pc       <= wb_next;
          instret  <= instret + INSTRET_W'(1);
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_addr <= wb_next;
        end
        default: ; // HALT and TRAP hold until reset
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_multicycle.sv
// Self-checking bench for mcpu_multicycle: a wait-state memory model, a
// transaction scoreboard, an ALU vector table and hand-written corner cases.
module tb_mcpu_multicycle;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ready, retire, halted, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instret, pc_dbg;
  logic [3:0]  mem_wstrb;

  mcpu_multicycle #(.RESET_PC(32'h0), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .instret(instret), .halted(halted), .trap(trap),
    .pc_dbg(pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  typedef struct {
    logic [31:0] instr;
    logic [11:0] v1;
    logic [11:0] v2;
    logic [31:0] expect_rd;
  } alu_vec_t;

  txn_t        exp_q[$];
  int          rt_q[$];
  logic [31:0] mem [0:255];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, wcnt = 0, wait_n = 0, first_req = -1;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr, hold_wdata;
  logic [5:0]  hold_ctl;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {f7, rs2, rs1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic exp_rd(input logic [31:0] addr);
    exp_q.push_back('{1'b0, addr, 32'h0, 4'h0});
  endtask

  task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    exp_q.push_back('{1'b1, addr, data, strb});
  endtask

  // Memory response: ready after wait_n wait cycles of a held request.
  initial forever begin
    @(negedge clk);
    if (!rst && mem_req) begin
      if (wcnt >= wait_n) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hxxxx_xxxx;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  // Completion edge: commit stores, score every transaction, snapshot waits.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst && mem_req && mem_ready) begin
      if (mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_wstrb[k]) mem[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
      end
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL txn_unexpected: got addr %h we %b, expected none", mem_addr, mem_we);
      end else begin
        txn_t e;
        e = exp_q.pop_front();
        check("txn_we", 32'(mem_we), 32'(e.we));
        check("txn_addr", mem_addr, e.addr);
        if (e.we) begin
          check("txn_wdata", mem_wdata, e.wdata);
          check("txn_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        end else begin
          check("txn_rd_wstrb", 32'(mem_wstrb), 32'h0);
        end
      end
      wcnt = 0;
    end
    hold_pend  = !rst && mem_req && !mem_ready;
    hold_addr  = mem_addr;
    hold_wdata = mem_wdata;
    hold_ctl   = {mem_req, mem_we, mem_wstrb};
  end

  // Mid-cycle monitor: request stability across waits, retire timestamps.
  initial forever begin
    @(negedge clk);
    if (hold_pend) begin
      check("hold_addr", mem_addr, hold_addr);
      check("hold_wdata", mem_wdata, hold_wdata);
      check("hold_ctl", 32'({mem_req, mem_we, mem_wstrb}), 32'(hold_ctl));
    end
    if (!rst) begin
      if (mem_req && first_req < 0) first_req = cyc;
      if (retire) rt_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic start();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_retire", 32'(retire), 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_halted", 32'({halted, trap}), 32'h0);
    check("rst_pc", pc_dbg, 32'h0);
    rt_q.delete();
    first_req = -1;
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", 32'(halted), 32'h1);
  endtask

  task automatic end_test();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic addi_sw_prog();
    clear_mem();
    mem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);  // addi x1,x0,5
    mem[1] = enc_s(12'h100, 5'd1, 5'd0, 3'd2);       // sw x1,0x100(x0)
    mem[2] = EBREAK;
    exp_rd(32'h0); exp_rd(32'h4); exp_wr(32'h100, 32'h5, 4'hF); exp_rd(32'h8);
  endtask

  alu_vec_t vecs[11];

  initial begin
    rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;

    vecs[0]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0), 12'd5,   12'd7,   32'd12};        // add
    vecs[1]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'd0), 12'd5,   12'd7,   32'hFFFF_FFFE}; // sub
    vecs[2]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd2), 12'hFFD, 12'd2,   32'd1};         // slt
    vecs[3]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd3), 12'hFFD, 12'd2,   32'd0};         // sltu
    vecs[4]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd4), 12'h0F0, 12'h0FF, 32'h0000_000F}; // xor
    vecs[5]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'd5), 12'hFF0, 12'd2,   32'hFFFF_FFFC}; // sra
    vecs[6]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd5), 12'hFF0, 12'd28,  32'h0000_000F}; // srl
    vecs[7]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd1), 12'd3,   12'd4,   32'd48};        // sll
    vecs[8]  = '{enc_i(12'h0F0, 5'd1, 3'd7, 5'd3, 7'h13), 12'h7FF, 12'd0, 32'h0F0}; // andi
    vecs[9]  = '{{20'h12345, 5'd3, 7'b0110111}, 12'd0, 12'd0, 32'h1234_5000};      // lui
    vecs[10] = '{{20'h00001, 5'd3, 7'b0010111}, 12'd0, 12'd0, 32'h0000_1008};      // auipc @0x8

    // Zero-wait addi/sw: first fetch at 0, first retire in cycle 4.
    wait_n = 0;
    addi_sw_prog();
    start();
    run_to_halt(200);
    check("t1_retire_count", 32'(rt_q.size()), 32'd2);
    if (rt_q.size() > 0) check("t1_first_retire_cycle", 32'(rt_q[0] - first_req + 1), 32'd4);
    check("t1_instret", instret, 32'd2);
    check("t1_trap", 32'(trap), 32'h0);
    check("t1_pc", pc_dbg, 32'h8);
    check("t1_mem", mem[8'h40], 32'h5);
    end_test();

    // Same program, three wait cycles on every request.
    wait_n = 3;
    addi_sw_prog();
    start();
    run_to_halt(400);
    if (rt_q.size() > 0) check("t2_first_retire_cycle", 32'(rt_q[0] - first_req + 1), 32'd7);
    check("t2_instret", instret, 32'd2);
    check("t2_mem", mem[8'h40], 32'h5);
    end_test();
    wait_n = 0;

    // ALU vector table: compute x3, store it to 0x180.
    for (int i = 0; i < 11; i++) begin
      clear_mem();
      mem[0] = enc_i(vecs[i].v1, 5'd0, 3'd0, 5'd1, 7'h13);
      mem[1] = enc_i(vecs[i].v2, 5'd0, 3'd0, 5'd2, 7'h13);
      mem[2] = vecs[i].instr;
      mem[3] = enc_s(12'h180, 5'd3, 5'd0, 3'd2);
      mem[4] = EBREAK;
      exp_rd(32'h0); exp_rd(32'h4); exp_rd(32'h8); exp_rd(32'hC);
      exp_wr(32'h180, vecs[i].expect_rd, 4'hF); exp_rd(32'h10);
      wait_n = i % 3;
      start();
      run_to_halt(300);
      check($sformatf("alu%0d_instret", i), instret, 32'd4);
      end_test();
    end
    wait_n = 0;

    // Byte loads with sign/zero extension and a replicated byte store.
    clear_mem();
    mem[8'h80] = 32'h80FF_1234;
    mem[0] = enc_i(12'h203, 5'd0, 3'd0, 5'd2, 7'h03);  // lb  x2,0x203(x0)
    mem[1] = enc_i(12'h203, 5'd0, 3'd4, 5'd3, 7'h03);  // lbu x3,0x203(x0)
    mem[2] = enc_s(12'h101, 5'd2, 5'd0, 3'd0);         // sb  x2,0x101(x0)
    mem[3] = enc_s(12'h104, 5'd2, 5'd0, 3'd2);         // sw  x2,0x104(x0)
    mem[4] = enc_s(12'h108, 5'd3, 5'd0, 3'd2);         // sw  x3,0x108(x0)
    mem[5] = EBREAK;
    exp_rd(32'h0); exp_rd(32'h200); exp_rd(32'h4); exp_rd(32'h200); exp_rd(32'h8);
    exp_wr(32'h100, 32'h8080_8080, 4'b0010); exp_rd(32'hC);
    exp_wr(32'h104, 32'hFFFF_FF80, 4'hF); exp_rd(32'h10);
    exp_wr(32'h108, 32'h0000_0080, 4'hF); exp_rd(32'h14);
    start();
    run_to_halt(300);
    check("ld_instret", instret, 32'd5);
    check("ld_sb_mem", mem[8'h40], 32'h0000_8000);
    end_test();

    // Branch and jumps with per-instruction latency.
    clear_mem();
    mem[0] = enc_j(21'd16, 5'd0);                  // 0x00: jal x0,+16
    mem[4] = enc_b(13'd8, 5'd0, 5'd0, 3'd0);       // 0x10: beq x0,x0,+8
    mem[6] = enc_j(21'h1F_FFF0, 5'd1);             // 0x18: jal x1,-16
    mem[2] = enc_s(12'h110, 5'd1, 5'd0, 3'd2);     // 0x08: sw x1,0x110(x0)
    mem[3] = EBREAK;                               // 0x0C
    exp_rd(32'h0); exp_rd(32'h10); exp_rd(32'h18); exp_rd(32'h8);
    exp_wr(32'h110, 32'h1C, 4'hF); exp_rd(32'hC);
    start();
    run_to_halt(300);
    check("br_retire_count", 32'(rt_q.size()), 32'd4);
    if (rt_q.size() == 4) begin
      check("br_beq_cycles", 32'(rt_q[1] - rt_q[0]), 32'd3);
      check("br_jal_cycles", 32'(rt_q[2] - rt_q[1]), 32'd4);
      check("br_sw_cycles", 32'(rt_q[3] - rt_q[2]), 32'd4);
    end
    check("br_pc", pc_dbg, 32'hC);
    end_test();

    // Misaligned word load traps before any data request.
    clear_mem();
    mem[0] = enc_i(12'h102, 5'd0, 3'd2, 5'd4, 7'h03);  // lw x4,0x102(x0)
    exp_rd(32'h0);
    start();
    run_to_halt(100);
    repeat (4) begin
      @(negedge clk);
      check("trap_mem_req", 32'(mem_req), 32'h0);
    end
    check("trap_flags", 32'({halted, trap}), 32'h3);
    check("trap_instret", instret, 32'h0);
    end_test();

    // Illegal opcode (all-zero word) also traps.
    clear_mem();
    exp_rd(32'h0);
    start();
    run_to_halt(100);
    check("illegal_flags", 32'({halted, trap}), 32'h3);
    end_test();

    // ebreak halts without trap and without retiring.
    clear_mem();
    mem[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13);
    mem[1] = EBREAK;
    exp_rd(32'h0); exp_rd(32'h4);
    start();
    run_to_halt(100);
    repeat (3) @(negedge clk);
    check("ebreak_flags", 32'({halted, trap}), 32'h2);
    check("ebreak_instret", instret, 32'h1);
    check("ebreak_mem_req", 32'(mem_req), 32'h0);
    end_test();

    // Reset during a store wait abandons it; restart fetches from RESET_PC.
    clear_mem();
    mem[8'h48] = 32'hDEAD_BEEF;
    mem[0] = enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'h13);
    mem[1] = enc_s(12'h120, 5'd1, 5'd0, 3'd2);
    exp_rd(32'h0); exp_rd(32'h4);
    wait_n = 5;
    start();
    begin
      int n = 0;
      while (!(mem_req && mem_we) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("rs_store_req_seen", 32'(mem_req && mem_we), 32'h1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rs_mem_req", 32'(mem_req), 32'h0);
    check("rs_wstrb", 32'(mem_wstrb), 32'h0);
    check("rs_instret", instret, 32'h0);
    check("rs_mem_kept", mem[8'h48], 32'hDEAD_BEEF);
    end_test();
    mem[0] = EBREAK;
    exp_rd(32'h0);
    wait_n = 0;
    first_req = -1;
    rst = 1'b0;
    run_to_halt(100);
    check("rs_restart_instret", instret, 32'h0);
    check("rs_restart_trap", 32'(trap), 32'h0);
    end_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
